// File: rtl/fixed_weight_loc_sampler_pkg.sv
// Shared constants and FSM encoding for the fixed-weight location sampler.
package fixed_weight_loc_sampler_pkg;

  // Code and sampling geometry
  localparam int unsigned N          = 17669;
  localparam int unsigned M          = 15;
  localparam int unsigned RAND_WIDTH = 24;
  localparam int unsigned WEIGHT     = 66;
  localparam int unsigned LOG_WEIGHT = $clog2(WEIGHT);
  localparam int unsigned CNT_W      = LOG_WEIGHT + 1;

  // Largest multiple of N below 2^RAND_WIDTH; keeps accepted candidates uniform mod N
  localparam int unsigned THRESHOLD  = ((2 ** RAND_WIDTH) / N) * N;

  // Barrett reduction constants
  localparam int unsigned      SHIFT  = RAND_WIDTH + M + 1;
  localparam longint unsigned  MU     = (64'd1 << SHIFT) / 64'(N);
  localparam int unsigned      MU_W   = $clog2(MU + 1);
  localparam int unsigned      PROD_W = RAND_WIDTH + MU_W;
  localparam int unsigned      Q_W    = PROD_W - SHIFT;
  localparam int unsigned      DIFF_W = RAND_WIDTH + 1;

  // Sampler control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/fixed_weight_loc_sampler_mod_n_reduce.sv
// Barrett mod-N pipe: registered quotient estimate, then subtract and one
// conditional correction. Fixed 2-cycle latency from in_* to the write edge.
module mod_n_reduce
  import fixed_weight_loc_sampler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [RAND_WIDTH-1:0] in_cand,
  output logic                  out_valid_c,
  output logic [M-1:0]          loc_c
);

  logic [PROD_W-1:0]     prod_c;
  logic [Q_W-1:0]        q_c;
  logic                  s2_valid;
  logic [RAND_WIDTH-1:0] s2_cand;
  logic [Q_W-1:0]        s2_q;
  logic [DIFF_W-1:0]     qn_c;
  logic [DIFF_W-1:0]     diff_c;

  // Full-width product, shifted only after the multiply
  always_comb begin
    prod_c = PROD_W'(in_cand) * PROD_W'(MU);
    q_c    = Q_W'(prod_c >> SHIFT);
  end

  // S2 register: quotient estimate travels with its candidate
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_cand  <= '0;
      s2_q     <= '0;
    end else begin
      s2_valid <= in_valid;
      s2_cand  <= in_cand;
      s2_q     <= q_c;
    end
  end

  // S3: estimate is low by at most one, so a single subtract of N corrects it
  always_comb begin
    qn_c        = DIFF_W'(s2_q) * DIFF_W'(N);
    diff_c      = DIFF_W'(s2_cand) - qn_c;
    out_valid_c = s2_valid;
    if (diff_c >= DIFF_W'(N)) begin
      loc_c = M'(diff_c - DIFF_W'(N));
    end else begin
      loc_c = M'(diff_c);
    end
  end

endmodule

// File: rtl/fixed_weight_loc_sampler.sv
// Rejection-samples WEIGHT locations in [0, N-1] from a random word stream and
// stores them in a small buffer for the one-hot error-vector generator.
// Optional build macro LOC_SAMPLER_STATS_EN adds a per-run reject counter.
module fixed_weight_loc_sampler
  import fixed_weight_loc_sampler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  input  logic [31:0]           rnd_in,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  input  logic [LOG_WEIGHT-1:0] rd_addr,
  input  logic                  rd_en,
  output logic [M-1:0]          location,
  output logic [CNT_W-1:0]      loc_count,
  output logic                  done
`ifdef LOC_SAMPLER_STATS_EN
  ,
  output logic [15:0]           reject_count
`endif
);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      issue_nxt;
  logic [CNT_W-1:0]      loc_nxt;
  logic                  clear_c;
  logic [RAND_WIDTH-1:0] cand_c;
  logic                  hs_c;
  logic                  acc_c;
  logic                  rej_c;
  logic                  unused_hi_c;
  logic                  s1_valid;
  logic [RAND_WIDTH-1:0] s1_cand;
  logic                  wr_c;
  logic [M-1:0]          wr_loc_c;
  logic [M-1:0]          loc_mem [WEIGHT];

  // Candidate accept test on the handshake cycle
  always_comb begin
    cand_c      = rnd_in[RAND_WIDTH-1:0];
    unused_hi_c = ^rnd_in[31:RAND_WIDTH];
    hs_c        = rnd_valid & rnd_ready;
    acc_c       = hs_c & (cand_c < RAND_WIDTH'(THRESHOLD));
    rej_c       = hs_c & ~acc_c;
  end

  // Next-state, issue counter and write counter
  always_comb begin
    state_nxt = state;
    issue_nxt = issue_cnt;
    clear_c   = 1'b0;
    loc_nxt   = wr_c ? loc_count + CNT_W'(1) : loc_count;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SAMPLE;
          clear_c   = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (acc_c) begin
          issue_nxt = issue_cnt + CNT_W'(1);
          if (issue_nxt == CNT_W'(WEIGHT)) begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (loc_nxt == CNT_W'(WEIGHT)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt = ST_SAMPLE;
          clear_c   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clear_c) begin
      issue_nxt = '0;
      loc_nxt   = '0;
    end
  end

  // State, counters and registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      issue_cnt <= '0;
      loc_count <= '0;
      ready     <= 1'b1;
      rnd_ready <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      issue_cnt <= issue_nxt;
      loc_count <= loc_nxt;
      ready     <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
      rnd_ready <= (state_nxt == ST_SAMPLE) && (issue_nxt < CNT_W'(WEIGHT));
      done      <= (state_nxt == ST_DONE);
    end
  end

  // S1: every candidate is registered; only the valid bit depends on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cand  <= '0;
    end else begin
      s1_valid <= acc_c;
      s1_cand  <= cand_c;
    end
  end

  mod_n_reduce u_reduce (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (s1_valid),
    .in_cand     (s1_cand),
    .out_valid_c (wr_c),
    .loc_c       (wr_loc_c)
  );

  // Location buffer write port
  always_ff @(posedge clk) begin
    if (wr_c) begin
      loc_mem[loc_count[LOG_WEIGHT-1:0]] <= wr_loc_c;
    end
  end

  // Registered read port; same-address write in the same cycle returns old data
  always_ff @(posedge clk) begin
    if (rst) begin
      location <= '0;
    end else if (rd_en) begin
      if (rd_addr < LOG_WEIGHT'(WEIGHT)) begin
        location <= loc_mem[rd_addr];
      end else begin
        location <= '0;
      end
    end
  end

`ifdef LOC_SAMPLER_STATS_EN
  // Per-run saturating reject counter
  always_ff @(posedge clk) begin
    if (rst) begin
      reject_count <= '0;
    end else if (clear_c) begin
      reject_count <= '0;
    end else if (rej_c && (reject_count != 16'hFFFF)) begin
      reject_count <= reject_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fixed_weight_loc_sampler.sv
// Directed + randomized bench for fixed_weight_loc_sampler with a location scoreboard.
module tb_fixed_weight_loc_sampler;

  localparam int unsigned N         = 17669;
  localparam int unsigned WEIGHT    = 66;
  localparam int unsigned THRESHOLD = 16767881;
  localparam int unsigned RMAX      = 16777215;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready;
  logic [31:0] rnd_in = '0;
  logic        rnd_valid = 1'b0;
  logic        rnd_ready;
  logic [6:0]  rd_addr = '0;
  logic        rd_en = 1'b0;
  logic [14:0] location;
  logic [7:0]  loc_count;
  logic        done;
`ifdef LOC_SAMPLER_STATS_EN
  logic [15:0] reject_count;
`endif

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int unsigned sb_q[$];

  fixed_weight_loc_sampler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ready     (ready),
    .rnd_in    (rnd_in),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .location  (location),
    .loc_count (loc_count),
    .done      (done)
`ifdef LOC_SAMPLER_STATS_EN
    ,
    .reject_count (reject_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_seen <= done_seen + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one word until handshake; pushes the model result when accepted
  task automatic send_word(input logic [31:0] w, output bit ok, output bit acc);
    int n = 0;
    int unsigned cand;
    rnd_in    = w;
    rnd_valid = 1'b1;
    while (!rnd_ready && n < 20) begin
      tick();
      n++;
    end
    ok   = rnd_ready;
    cand = w & 32'h00FF_FFFF;
    acc  = ok && (cand < THRESHOLD);
    if (ok) begin
      if (acc) sb_q.push_back(cand % N);
      tick();
    end
    rnd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    check("done_seen", done, 1);
    check("loc_count_at_done", loc_count, WEIGHT);
    tick();
    check("done_one_cycle", done, 0);
    check("ready_after_done", ready, 1);
  endtask

  task automatic read_all();
    int unsigned exp;
    check("sb_size", sb_q.size(), WEIGHT);
    for (int i = 0; i < int'(WEIGHT); i++) begin
      rd_addr = 7'(i);
      rd_en   = 1'b1;
      tick();
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hFFFF_FFFF;
      check($sformatf("loc[%0d]", i), location, exp);
    end
    rd_en = 1'b0;
    sb_q.delete();
  endtask

  // One full run with random valid gaps and a share of forced rejects
  task automatic do_run(input int gap_max, input int rej_pct);
    int d0;
    int accepted = 0;
    bit ok, acc;
    logic [31:0] w;
    d0 = done_seen;
    pulse_start();
    check("run_ready_low", ready, 0);
    while (accepted < int'(WEIGHT)) begin
      repeat ($urandom_range(0, gap_max)) tick();
      if ($urandom_range(0, 99) < rej_pct)
        w = {8'($urandom), 24'(THRESHOLD + $urandom_range(0, RMAX - THRESHOLD))};
      else
        w = $urandom;
      send_word(w, ok, acc);
      if (!ok) begin
        check("run_handshake", ok, 1);
        return;
      end
      if (acc) accepted++;
    end
    wait_done(10);
    check("done_once_per_run", done_seen - d0, 1);
    read_all();
  endtask

  initial begin
    bit ok, acc;
    int d0;

    // Reset values
    tick();
    tick();
    check("rst_ready", ready, 1);
    check("rst_rnd_ready", rnd_ready, 0);
    check("rst_done", done, 0);
    check("rst_loc_count", loc_count, 0);
    check("rst_location", location, 0);
    rst = 1'b0;
    tick();

    // 1: 66 back-to-back words 0..65
    pulse_start();
    check("t1_ready_low", ready, 0);
    check("t1_rnd_ready", rnd_ready, 1);
    for (int i = 0; i < int'(WEIGHT); i++) send_word(32'(i), ok, acc);
    check("t1_rnd_ready_low", rnd_ready, 0);
    check("t1_done_e0", done, 0);
    rnd_in    = 32'd7;
    rnd_valid = 1'b1;
    tick();
    check("t1_done_e1", done, 0);
    tick();
    check("t1_done_e2", done, 1);
    check("t1_loc_count", loc_count, WEIGHT);
    tick();
    tick();
    check("t1_no_overshoot", loc_count, WEIGHT);
    check("t1_idle_ready", ready, 1);
    rnd_valid = 1'b0;
    read_all();

    // 2/3: reject boundaries, mod boundaries, overlapped read, start while busy
    pulse_start();
    send_word(32'(THRESHOLD), ok, acc);
    check("t2_thr_rejected", acc, 0);
    send_word(32'(RMAX), ok, acc);
    send_word(32'd5, ok, acc);
    tick();
    tick();
    check("t2_loc_count", loc_count, 1);
    check("t2_still_sampling", rnd_ready, 1);
    rd_addr = 7'd0;
    rd_en   = 1'b1;
    tick();
    rd_en   = 1'b0;
    check("t2_overlap_read", location, 5);
    pulse_start();
    check("t2_start_ignored", loc_count, 1);
    check("t2_busy_ready", ready, 0);
    send_word(32'd17669, ok, acc);
    send_word(32'd35338, ok, acc);
    send_word(32'(THRESHOLD - 1), ok, acc);
    check("t3_thr_m1_accepted", acc, 1);
    send_word(32'hAB00_0007, ok, acc);
    for (int i = 0; i < 61; i++) send_word(32'(i * 257 + 3), ok, acc);
    wait_done(10);
    rd_addr = 7'd3;
    rd_en   = 1'b1;
    tick();
    rd_en   = 1'b0;
    check("t3_max_loc", location, N - 1);
    read_all();

    // 4: randomized runs against the mod-N/reject model
    for (int r = 0; r < 30; r++) do_run(2, 10);

`ifdef LOC_SAMPLER_STATS_EN
    // 6: ten rejects interleaved with 66 accepts
    begin
      int nrej = 0;
      pulse_start();
      for (int i = 0; i < 76; i++) begin
        if ((i % 7 == 3) && nrej < 10) begin
          send_word(32'(THRESHOLD + 32'(i)), ok, acc);
          nrej++;
        end else begin
          send_word(32'(i * 1000 + i), ok, acc);
        end
      end
      wait_done(10);
      check("t6_reject_count", reject_count, 10);
      read_all();
      pulse_start();
      check("t6_reject_cleared", reject_count, 0);
      for (int i = 0; i < int'(WEIGHT); i++) send_word(32'(i + 100), ok, acc);
      wait_done(10);
      read_all();
    end
`endif

    // 5: reset mid-run at loc_count == 30
    pulse_start();
    rnd_in    = 32'd100;
    rnd_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (loc_count == 8'd30) break;
      tick();
    end
    check("t5_reached_30", loc_count, 30);
    d0  = done_seen;
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    rnd_valid = 1'b0;
    check("t5_ready", ready, 1);
    check("t5_loc_count", loc_count, 0);
    check("t5_rnd_ready", rnd_ready, 0);
    check("t5_done", done, 0);
    repeat (5) tick();
    check("t5_no_done_pulse", done_seen - d0, 0);
    sb_q.delete();
    do_run(1, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
